// File: rtl/servo_pkg.sv
// Shared constants and the per-frame step rule for the servo PWM bank.
package servo_pkg;

  localparam int FRAME_CYCLES_DEF = 1_000_000;
  localparam int MIN_CYC_DEF      = 50_000;
  localparam int STEP_CYC_DEF     = 196;
  localparam int CENTER_DEF       = 128;

  // Move pos toward tgt by at most slew; slew of 0 means jump straight to tgt.
  // The result always lies between pos and tgt, so it can never wrap.
  function automatic int step_toward(int pos, int tgt, int slew);
    int d;
    d = tgt - pos;
    if (slew == 0 || (d <= slew && d >= -slew)) return tgt;
    if (d > 0) return pos + slew;
    return pos - slew;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: target and slewed position registers plus the pulse comparator.
module servo_channel
  import servo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 20,
  parameter int MIN_CYC  = MIN_CYC_DEF,
  parameter int STEP_CYC = STEP_CYC_DEF,
  parameter int CENTER   = CENTER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              frame_edge_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] pend_i,
  input  logic [DATA_W-1:0] slew_i,
  input  logic [CNT_W-1:0]  cnt_d_i,
  output logic [DATA_W-1:0] pos_o,
  output logic              pwm_o,
  output logic              at_tgt_o
);

  localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP_CYC);

  logic [DATA_W-1:0] pos_q, pos_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic              pwm_q, pwm_d;
  logic [CNT_W-1:0]  width;

  // The pulse is compared against the next count and next position, so the
  // registered output lines up exactly with the frame counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pos_d = pos_q;
    tgt_d = tgt_q;
    if (frame_edge_i)
      pos_d = DATA_W'(step_toward(int'(pos_q), int'(tgt_q), int'(slew_i)));
    if (load_i)
      tgt_d = pend_i;
    width = MIN_W + CNT_W'(pos_d) * STEP_W;
    pwm_d = en_i && (cnt_d_i < width);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      pos_q <= DATA_W'(CENTER);
      tgt_q <= DATA_W'(CENTER);
      pwm_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      tgt_q <= tgt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pos_o    = pos_q;
  assign pwm_o    = pwm_q;
  assign at_tgt_o = (pos_q == tgt_q);

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of slew-limited servo PWM channels sharing one frame counter and a
// one-entry pending target buffer with a valid/ready handshake.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int DATA_W       = 8,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int MIN_CYC      = MIN_CYC_DEF,
  parameter int STEP_CYC     = STEP_CYC_DEF,
  parameter int CENTER       = CENTER_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DATA_W-1:0]      slew,
  input  logic                   tgt_valid,
  output logic                   tgt_ready,
  input  logic [N_CH*DATA_W-1:0] tgt_data,
  output logic [N_CH-1:0]        pwm_out,
  output logic [N_CH*DATA_W-1:0] pos_out,
  output logic                   frame_tick,
  output logic                   settled
);

  localparam int CNT_W = $clog2(FRAME_CYCLES);

  if (MIN_CYC + (2**DATA_W - 1) * STEP_CYC >= FRAME_CYCLES) begin : g_bad_timing
    $fatal(1, "servo_pwm_bank: widest pulse does not fit inside the frame");
  end

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   en_q;
  logic                   frame_edge;
  logic                   pend_full_q, pend_full_d;
  logic [N_CH*DATA_W-1:0] pend_q;
  logic                   ready_q, tick_q, settled_q;
  logic                   accept, load;
  logic [N_CH-1:0]        at_tgt;

  assign accept = tgt_valid && ready_q;
  assign load   = frame_edge && pend_full_q;

  // A frame starts on wrap or on the first enabled edge after a disabled one;
  // cnt is forced to 0 there so a re-enable always begins a full frame.
  always_comb begin
    frame_edge  = en && (!en_q || cnt_q == CNT_W'(FRAME_CYCLES - 1));
    cnt_d       = '0;
    if (en && !frame_edge)
      cnt_d = cnt_q + 1'b1;
    pend_full_d = pend_full_q;
    if (load)
      pend_full_d = 1'b0;
    if (accept)
      pend_full_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      en_q        <= 1'b0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b0;
      tick_q      <= 1'b0;
      settled_q   <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      en_q        <= en;
      pend_full_q <= pend_full_d;
      ready_q     <= !pend_full_d;
      tick_q      <= frame_edge;
      settled_q   <= (&at_tgt) && !pend_full_q;
    end
  end

  // NOTE: pending data needs no reset; pend_full_q alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (accept)
      pend_q <= tgt_data;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_channel #(
      .DATA_W  (DATA_W),
      .CNT_W   (CNT_W),
      .MIN_CYC (MIN_CYC),
      .STEP_CYC(STEP_CYC),
      .CENTER  (CENTER)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en),
      .frame_edge_i(frame_edge),
      .load_i      (load),
      .pend_i      (pend_q[i*DATA_W +: DATA_W]),
      .slew_i      (slew),
      .cnt_d_i     (cnt_d),
      .pos_o       (pos_out[i*DATA_W +: DATA_W]),
      .pwm_o       (pwm_out[i]),
      .at_tgt_o    (at_tgt[i])
    );
  end

  assign tgt_ready  = ready_q;
  assign frame_tick = tick_q;
  assign settled    = settled_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank: frame-level reference model checked
// every cycle, a table of target vectors, and directed multi-frame sequences.
module tb_servo_pwm_bank;

  localparam int N_CH     = 3;
  localparam int DATA_W   = 8;
  localparam int FC       = 1000;
  localparam int MIN_CYC  = 50;
  localparam int STEP_CYC = 2;
  localparam int CENTER   = 128;
  localparam int VW       = N_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst, en, tgt_valid, tgt_ready, frame_tick, settled;
  logic [DATA_W-1:0] slew;
  logic [VW-1:0]     tgt_data, pos_out;
  logic [N_CH-1:0]   pwm_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  servo_pwm_bank #(
    .N_CH(N_CH), .DATA_W(DATA_W), .FRAME_CYCLES(FC),
    .MIN_CYC(MIN_CYC), .STEP_CYC(STEP_CYC), .CENTER(CENTER)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .slew(slew),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_data(tgt_data),
    .pwm_out(pwm_out), .pos_out(pos_out), .frame_tick(frame_tick), .settled(settled)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Reference model: frame phase, target arrays and a queue of pending vectors.
  int            m_pos[N_CH];
  int            m_tgt[N_CH];
  logic [VW-1:0] m_q[$];
  bit            m_run, m_ready, m_tick, m_settled;
  int            m_phase;
  bit [N_CH-1:0] m_pwm;

  function automatic int move(int p, int t, int s);
    int gap, mag;
    gap = t - p;
    mag = (gap < 0) ? -gap : gap;
    if (s == 0 || mag <= s) return t;
    return (gap > 0) ? p + s : p - s;
  endfunction

  task automatic model_edge();
    bit            fe, acc, st;
    logic [VW-1:0] v;
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        m_pos[i] = CENTER;
        m_tgt[i] = CENTER;
      end
      m_q.delete();
      m_run = 0; m_phase = 0; m_ready = 0; m_tick = 0; m_settled = 1; m_pwm = '0;
      return;
    end
    st = (m_q.size() == 0);
    for (int i = 0; i < N_CH; i++) st &= (m_pos[i] == m_tgt[i]);
    acc = tgt_valid && m_ready;
    fe  = en && (!m_run || m_phase == FC - 1);
    if (fe) begin
      for (int i = 0; i < N_CH; i++) m_pos[i] = move(m_pos[i], m_tgt[i], int'(slew));
      if (m_q.size() != 0) begin
        v = m_q.pop_front();
        for (int i = 0; i < N_CH; i++) m_tgt[i] = int'(v[i*DATA_W +: DATA_W]);
      end
    end
    if (acc) m_q.push_back(tgt_data);
    m_phase   = (en && !fe) ? m_phase + 1 : 0;
    m_run     = en;
    m_tick    = fe;
    m_ready   = (m_q.size() == 0);
    m_settled = st;
    for (int i = 0; i < N_CH; i++)
      m_pwm[i] = en && (m_phase < MIN_CYC + m_pos[i] * STEP_CYC);
  endtask

  function automatic logic [63:0] model_vec();
    logic [VW-1:0] p;
    for (int i = 0; i < N_CH; i++) p[i*DATA_W +: DATA_W] = DATA_W'(m_pos[i]);
    return 64'({m_pwm, p, m_ready, m_tick, m_settled});
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", 64'({pwm_out, pos_out, tgt_ready, frame_tick, settled}), model_vec());
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 3 * FC; k++) begin
      cycle();
      if (frame_tick === 1'b1) return;
    end
    timeout("frame_tick");
  endtask

  int meas_w[N_CH];

  // Starts on the first cycle of a frame and stops on its last cycle.
  task automatic measure();
    for (int c = 0; c < N_CH; c++) meas_w[c] = 0;
    for (int k = 0; k < FC; k++) begin
      if (k > 0) cycle();
      for (int c = 0; c < N_CH; c++) if (pwm_out[c] === 1'b1) meas_w[c]++;
    end
  endtask

  task automatic send(input logic [VW-1:0] v);
    bit r;
    tgt_valid = 1'b1;
    tgt_data  = v;
    for (int k = 0; k < 3 * FC; k++) begin
      r = tgt_ready;
      cycle();
      if (r) begin
        tgt_valid = 1'b0;
        return;
      end
    end
    tgt_valid = 1'b0;
    timeout("tgt_ready");
  endtask

  typedef struct {
    logic [7:0]  slew;
    logic [23:0] tgt;
    logic [23:0] exp_pos;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, highs;

    // Expected positions two frame edges after each transfer; channel 2 is the top byte.
    tbl[0] = '{slew: 8'd0,  tgt: 24'h000000, exp_pos: 24'h000000};
    tbl[1] = '{slew: 8'd0,  tgt: 24'hFF0164, exp_pos: 24'hFF0164};
    tbl[2] = '{slew: 8'd20, tgt: 24'hF5155A, exp_pos: 24'hF5155A};
    tbl[3] = '{slew: 8'd5,  tgt: 24'h00FF5A, exp_pos: 24'hF01A5A};
    tbl[4] = '{slew: 8'd0,  tgt: 24'h808080, exp_pos: 24'h808080};

    rst = 1'b1; en = 1'b1; slew = '0; tgt_valid = 1'b0; tgt_data = '0;
    cycle();
    cycle();
    check("rst_pwm", 64'(pwm_out), 0);
    check("rst_pos", 64'(pos_out), 64'h808080);
    check("rst_ready", 64'(tgt_ready), 0);
    check("rst_tick", 64'(frame_tick), 0);
    check("rst_settled", 64'(settled), 1);

    rst = 1'b0;
    cycle();
    check("first_tick", 64'(frame_tick), 1);
    check("ready_after_rst", 64'(tgt_ready), 1);
    measure();
    for (int c = 0; c < N_CH; c++) check("width_center", 64'(meas_w[c]), 306);
    check("settled_center", 64'(settled), 1);

    for (int t = 0; t < 5; t++) begin
      wait_tick();
      slew = tbl[t].slew;
      send(tbl[t].tgt);
      wait_tick();
      wait_tick();
      check("tbl_pos", 64'(pos_out), 64'(tbl[t].exp_pos));
      measure();
      for (int c = 0; c < N_CH; c++)
        check("tbl_width", 64'(meas_w[c]),
              64'(MIN_CYC + STEP_CYC * int'(tbl[t].exp_pos[c*8 +: 8])));
    end

    // Slewed ramp on channel 0: 128 -> 200 in steps of 10.
    wait_tick();
    slew = 8'd10;
    send(24'h8080C8);
    wait_tick();
    check("ramp_hold", 64'(pos_out[7:0]), 128);
    for (int k = 1; k <= 8; k++) begin
      wait_tick();
      check("ramp_pos", 64'(pos_out[7:0]), 64'((k < 8) ? 128 + 10 * k : 200));
    end
    check("ramp_not_settled", 64'(settled), 0);
    cycle();
    check("ramp_settled", 64'(settled), 1);

    // Back-to-back vectors.
    slew = 8'd0;
    wait_tick();
    tgt_valid = 1'b1;
    tgt_data  = 24'h102030;
    check("b2b_ready_a", 64'(tgt_ready), 1);
    cycle();
    tgt_data = 24'h405060;
    check("b2b_ready_full", 64'(tgt_ready), 0);
    wait_tick();
    check("b2b_ready_edge", 64'(tgt_ready), 1);
    check("b2b_pos_old", 64'(pos_out), 64'h8080C8);
    cycle();
    tgt_valid = 1'b0;
    check("b2b_ready_full_b", 64'(tgt_ready), 0);
    wait_tick();
    check("b2b_pos_a", 64'(pos_out), 64'h102030);
    wait_tick();
    check("b2b_pos_b", 64'(pos_out), 64'h405060);

    // Reset mid-ramp with a vector pending.
    slew = 8'd5;
    wait_tick();
    send(24'hFFFFFF);
    wait_tick();
    send(24'h000000);
    wait_tick();
    check("ramp_started", 64'(pos_out), 64'h455565);
    send(24'h111111);
    repeat (20) cycle();
    check("pend_full", 64'(tgt_ready), 0);
    check("pwm_live", 64'(pwm_out), 64'b111);
    rst = 1'b1;
    cycle();
    check("midrst_pwm", 64'(pwm_out), 0);
    check("midrst_pos", 64'(pos_out), 64'h808080);
    check("midrst_ready", 64'(tgt_ready), 0);
    check("midrst_tick", 64'(frame_tick), 0);
    check("midrst_settled", 64'(settled), 1);
    rst = 1'b0;
    cycle();
    check("midrst_first_tick", 64'(frame_tick), 1);
    check("midrst_ready_back", 64'(tgt_ready), 1);
    measure();
    for (int c = 0; c < N_CH; c++) check("midrst_width", 64'(meas_w[c]), 306);
    wait_tick();
    check("midrst_no_residual", 64'(pos_out), 64'h808080);

    // Enable dropped at cnt=100, then re-enabled.
    slew = 8'd0;
    repeat (100) cycle();
    en = 1'b0;
    cycle();
    check("en_off_pwm", 64'(pwm_out), 0);
    check("en_off_tick", 64'(frame_tick), 0);
    ticks = 0;
    highs = 0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (frame_tick === 1'b1) ticks++;
      if (pwm_out !== '0) highs++;
    end
    check("en_off_ticks", 64'(ticks), 0);
    check("en_off_highs", 64'(highs), 0);
    en = 1'b1;
    cycle();
    check("en_on_tick", 64'(frame_tick), 1);
    measure();
    for (int c = 0; c < N_CH; c++) check("en_on_width", 64'(meas_w[c]), 306);

    // Randomized traffic, enable toggles and one reset, checked by the model.
    slew = DATA_W'($urandom_range(1, 30));
    for (int k = 0; k < 12000; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        tgt_valid = 1'b1;
        tgt_data  = VW'($urandom);
      end else begin
        tgt_valid = 1'b0;
      end
      if ($urandom_range(0, 1999) == 0) slew = DATA_W'($urandom_range(0, 40));
      if ($urandom_range(0, 2499) == 0) en = ~en;
      rst = (k == 7000);
      cycle();
    end
    rst = 1'b0;
    tgt_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
